// File: rtl/ping_pong_ctrl_pkg.sv
// Shared types and helpers for the ping-pong buffer sequencer.
package ping_pong_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWITCH = 2'd1,
        SETTLE = 2'd2
    } pp_ctrl_state_t;

    // Bits needed to hold the unsigned value 'value' (at least 1).
    function automatic int bw(input int value);
        return (value < 2) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer sequencer: producer/consumer handshakes, switch pulse, settle hold-off.
// Optional stall counters are built when PP_CTRL_PERF_EN is defined.
module ping_pong_ctrl
    import ping_pong_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             prod_req,
    input  logic             prod_done,
    output logic             cons_req,
    input  logic             cons_done,
    output logic             switch,
    output logic             bank,
    output logic             busy,
    output logic [CNT_W-1:0] swap_cnt,
    output logic [CNT_W-1:0] prod_stall_cnt,
    output logic [CNT_W-1:0] cons_stall_cnt
);

    localparam int             SW          = bw(SETTLE_CYC);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYC - 1);

    pp_ctrl_state_t   state, next_state;
    logic [SW-1:0]    settle_cnt, next_settle_cnt;
    logic             wr_full, next_wr_full;
    logic             rd_valid, next_rd_valid;
    logic             next_prod_req, next_cons_req;
    logic             next_switch, next_bank, next_busy;
    logic [CNT_W-1:0] next_swap_cnt;
    logic             swap_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            wr_full    <= 1'b0;
            rd_valid   <= 1'b0;
            prod_req   <= 1'b0;
            cons_req   <= 1'b0;
            switch     <= 1'b0;
            bank       <= 1'b0;
            busy       <= 1'b0;
            swap_cnt   <= '0;
        end else begin
            settle_cnt <= next_settle_cnt;
            wr_full    <= next_wr_full;
            rd_valid   <= next_rd_valid;
            prod_req   <= next_prod_req;
            cons_req   <= next_cons_req;
            switch     <= next_switch;
            bank       <= next_bank;
            busy       <= next_busy;
            swap_cnt   <= next_swap_cnt;
        end
    end

    // Swap only once both halves are idle; en is deliberately ignored here.
    assign swap_go = wr_full & ~rd_valid & ~prod_req & ~cons_req;

    always_comb begin
        next_state      = state;
        next_settle_cnt = settle_cnt;
        next_wr_full    = wr_full;
        next_rd_valid   = rd_valid;
        next_prod_req   = prod_req;
        next_cons_req   = cons_req;
        next_switch     = 1'b0;
        next_bank       = bank;
        next_swap_cnt   = swap_cnt;

        case (state)
            RUN: begin
                if (swap_go) begin
                    next_state  = SWITCH;
                    next_switch = 1'b1;
                end else begin
                    if (prod_done && prod_req) begin
                        next_prod_req = 1'b0;
                        next_wr_full  = 1'b1;
                    end else if (en && !wr_full && !prod_req) begin
                        next_prod_req = 1'b1;
                    end
                    if (cons_done && cons_req) begin
                        next_cons_req = 1'b0;
                        next_rd_valid = 1'b0;
                    end else if (en && rd_valid && !cons_req) begin
                        next_cons_req = 1'b1;
                    end
                end
            end
            SWITCH: begin
                next_state      = SETTLE;
                next_settle_cnt = '0;
                next_bank       = ~bank;
                next_swap_cnt   = swap_cnt + CNT_W'(1);
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state    = RUN;
                    next_wr_full  = 1'b0;
                    next_rd_valid = 1'b1;
                    next_prod_req = en;
                    next_cons_req = en;
                end else begin
                    next_settle_cnt = settle_cnt + SW'(1);
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase

        next_busy = (next_state != RUN) | next_prod_req | next_cons_req;
    end

`ifdef PP_CTRL_PERF_EN
    logic prod_stall_inc, cons_stall_inc;

    assign prod_stall_inc = (state == RUN) & wr_full & rd_valid;
    assign cons_stall_inc = (state == RUN) & ~rd_valid & ~wr_full & prod_req;

    sat_counter #(.CNT_W(CNT_W)) u_prod_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (prod_stall_inc),
        .cnt   (prod_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cons_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (cons_stall_inc),
        .cnt   (cons_stall_cnt)
    );
`else
    assign prod_stall_cnt = '0;
    assign cons_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Scoreboard bench for ping_pong_ctrl: a transaction-level model predicts switch
// events into a queue that a separate monitor drains; request levels are checked each cycle.
module tb_ping_pong_ctrl;

    localparam int S     = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             prod_done = 1'b0;
    logic             cons_done = 1'b0;
    logic             prod_req, cons_req, switch, bank, busy;
    logic [CNT_W-1:0] swap_cnt, prod_stall_cnt, cons_stall_cnt;

    ping_pong_ctrl #(.SETTLE_CYC(S), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .prod_req       (prod_req),
        .prod_done      (prod_done),
        .cons_req       (cons_req),
        .cons_done      (cons_done),
        .switch         (switch),
        .bank           (bank),
        .busy           (busy),
        .swap_cnt       (swap_cnt),
        .prod_stall_cnt (prod_stall_cnt),
        .cons_stall_cnt (cons_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at;
        int cnt;
        int bnk;
    } sw_exp_t;

    sw_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc;
    bit mon_on = 1'b0;

    // Reference model: half-buffer ownership plus the cycle windows around each swap.
    bit m_preq, m_creq, m_filled, m_loaded, m_bank;
    int m_swaps, resume_at, switch_at, last_switch;
    int m_pstall, m_cstall;

    task automatic compare(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        m_preq = 0; m_creq = 0; m_filled = 0; m_loaded = 0; m_bank = 0;
        m_swaps = 0; resume_at = 0; switch_at = -1; last_switch = -1;
        m_pstall = 0; m_cstall = 0;
        exp_q.delete();
        cyc = 0;
    endtask

    // Advance the model across the edge that ends cycle 'cyc'.
    task automatic modelStep(input bit pd, input bit cd, input bit e);
        bit running;
        running = (cyc >= resume_at);
        if (running && m_filled && m_loaded && m_pstall < 65535) m_pstall++;
        if (running && !m_loaded && !m_filled && m_preq && m_cstall < 65535) m_cstall++;
        if (cyc == switch_at) begin
            m_swaps++;
            m_bank = ~m_bank;
        end
        if (cyc + 1 == resume_at) begin
            m_filled = 0; m_loaded = 1; m_preq = e; m_creq = e;
        end else if (running) begin
            if (m_filled && !m_loaded && !m_preq && !m_creq) begin
                switch_at = cyc + 1;
                resume_at = cyc + 2 + S;
                exp_q.push_back('{at: cyc + 1, cnt: m_swaps, bnk: int'(m_bank)});
            end else begin
                if (pd && m_preq) begin m_preq = 0; m_filled = 1; end
                else if (e && !m_filled && !m_preq) m_preq = 1;
                if (cd && m_creq) begin m_creq = 0; m_loaded = 0; end
                else if (e && m_loaded && !m_creq) m_creq = 1;
            end
        end
    endtask

    task automatic checkOutput();
        bit missed;
        compare("prod_req", prod_req, m_preq);
        compare("cons_req", cons_req, m_creq);
        compare("busy", busy, (cyc < resume_at) || m_preq || m_creq);
        compare("bank", bank, m_bank);
        compare("swap_cnt", swap_cnt, m_swaps % 65536);
`ifdef PP_CTRL_PERF_EN
        compare("prod_stall_cnt", prod_stall_cnt, m_pstall);
        compare("cons_stall_cnt", cons_stall_cnt, m_cstall);
`else
        compare("prod_stall_cnt", prod_stall_cnt, 0);
        compare("cons_stall_cnt", cons_stall_cnt, 0);
`endif
        missed = (exp_q.size() > 0) && (exp_q[0].at < cyc);
        compare("switch_missing", missed, 0);
        if (missed) void'(exp_q.pop_front());
    endtask

    // Drive one cycle of inputs from the negedge, step the model at the edge, check at the next negedge.
    task automatic applyStimulus(input bit pd, input bit cd, input bit e);
        prod_done = pd;
        cons_done = cd;
        en        = e;
        @(posedge clk);
        modelStep(pd, cd, e);
        cyc++;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic resetDut();
        mon_on    = 1'b0;
        rst_n     = 1'b0;
        prod_done = 1'b0;
        cons_done = 1'b0;
        en        = 1'b0;
        repeat (3) @(negedge clk);
        modelReset();
        rst_n  = 1'b1;
        mon_on = 1'b1;
        checkOutput();
    endtask

    // Monitor: every switch pulse must match the next predicted swap.
    always @(negedge clk) begin
        if (mon_on && rst_n && switch) begin
            if (exp_q.size() == 0) begin
                compare("switch_unexpected", 1, 0);
            end else begin
                sw_exp_t x;
                x = exp_q.pop_front();
                compare("switch_cycle", cyc, x.at);
                compare("switch_swap_cnt", swap_cnt, x.cnt % 65536);
                compare("switch_bank", bank, x.bnk);
                if (last_switch >= 0)
                    compare("switch_spacing_ok", (cyc - last_switch) >= S + 3, 1);
                last_switch = cyc;
            end
        end
    end

    initial begin
        int base;
        int guard;
        modelReset();

        // Directed: one fill at 5, then producer at 20 finishes before consumer at 30.
        resetDut();
        for (int i = 0; i < 40; i++)
            applyStimulus(i == 5 || i == 20, i == 30, 1'b1);

        // Back-to-back swaps with both dones held high.
        base  = m_swaps;
        guard = 0;
        while (m_swaps < base + 100 && guard < 2000) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            guard++;
        end
        compare("hundred_swaps", m_swaps - base, 100);

        // Randomized traffic with en toggling and stray done pulses.
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) != 0);

        // Asynchronous reset in the middle of a settle window.
        guard = 0;
        while (!(cyc > switch_at && cyc < resume_at && switch_at >= 0) && guard < 200) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            guard++;
        end
        compare("reached_settle", guard < 200, 1);
        #1;
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        compare("async_prod_req", prod_req, 0);
        compare("async_cons_req", cons_req, 0);
        compare("async_busy", busy, 0);
        compare("async_bank", bank, 0);
        compare("async_swap_cnt", swap_cnt, 0);
        compare("async_switch", switch, 0);
        resetDut();
        for (int i = 0; i < 200; i++)
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'b1);

        compare("queue_drained", exp_q.size() <= 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ping_pong_ctrl.md
# ping_pong_ctrl

Sequencer for the dual-port ping-pong buffer. It hands the write half to a producer and the read half to a consumer through req/done handshakes. When the producer has filled its half and the consumer has drained the other, it issues the one-cycle `switch` pulse, then holds both sides off until the buffer's registered address/data pipeline has settled. It sits between the layer scheduler's producer/consumer engines and the buffer's `switch` input.

## Interface
- `SETTLE_CYC`, 2: idle cycles after `switch` before new requests; legal range 1..15.
- `CNT_W`, 16: width of `swap_cnt` and the perf counters.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: permits new requests; does not abort transfers already granted.
- `prod_req` out 1: the write half is free; the producer may fill it.
- `prod_done` in 1: one-cycle pulse, fill complete.
- `cons_req` out 1: the read half holds valid data; the consumer may drain it.
- `cons_done` in 1: one-cycle pulse, drain complete.
- `switch` out 1: one-cycle pulse to the buffer.
- `bank` out 1: toggles on each `switch`; informational only.
- `busy` out 1: high whenever the state is not RUN, or either req is high.
- `swap_cnt` out CNT_W: number of switches; wraps.
- `prod_stall_cnt`, `cons_stall_cnt` out CNT_W: perf counters (see Configuration).

## Operation
- Internal flags:
  - `wr_full`: write half filled, not yet swapped.
  - `rd_valid`: read half holds undrained data.
- States:
  - RUN: normal handshaking.
  - SWITCH: one cycle, `switch`=1.
  - SETTLE: counts SETTLE_CYC cycles.
- In RUN:
  - `prod_req` rises when `en & ~wr_full & ~prod_req`.
  - `cons_req` rises when `en & rd_valid & ~cons_req`.
- A req stays high until its done pulse.
  - `prod_done` with `prod_req`=1: clears `prod_req`, sets `wr_full`.
  - `cons_done` with `cons_req`=1: clears `cons_req`, clears `rd_valid`.
  - A done pulse while its req is low is ignored.
- RUN → SWITCH when `wr_full & ~rd_valid & ~prod_req & ~cons_req`. The swap is unaffected by `en`, so buffered data always drains.
- SWITCH → SETTLE unconditionally. `bank` toggles and `swap_cnt` increments on this transition.
- SETTLE → RUN after SETTLE_CYC cycles. On that same edge:
  - `wr_full`←0 and `rd_valid`←1.
  - `prod_req`←`en` and `cons_req`←`en`.
- No req can rise during SWITCH or SETTLE.
- Simultaneous `prod_done` and `cons_done` in one cycle: both are accepted.
- Reset values: all outputs 0, state RUN, `wr_full`=0, `rd_valid`=0.
- Reset mid-transfer: reqs drop asynchronously and in-flight data is discarded.
- The buffer's internal bank flag has no reset. Its absolute parity is irrelevant because each port always addresses its own logical half; `bank` only tracks relative parity.

## Timing
- All outputs are registered.
- Handshake response:
  - `prod_done` sampled at edge N: `prod_req`=0 and `wr_full`=1 from cycle N+1.
  - The same timing applies to `cons_done` / `rd_valid`.
- Swap latency, when the swap condition holds in cycle N+1:
  - `switch`=1 in cycle N+2.
  - SETTLE spans cycles N+3 .. N+2+SETTLE_CYC.
  - Both reqs are high from cycle N+3+SETTLE_CYC.
- `switch` is never asserted on consecutive cycles. The minimum spacing between switches is SETTLE_CYC+3 cycles.
- First fill after reset: with `en`=1, `prod_req` rises 1 cycle after `rst_n` deasserts.

## Configuration
- Macro: `PP_CTRL_PERF_EN`.
- Defined:
  - `prod_stall_cnt` increments every RUN cycle with `wr_full & rd_valid` (producer blocked by the consumer).
  - `cons_stall_cnt` increments every RUN cycle with `~rd_valid & ~wr_full & prod_req` (consumer starved).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter logic is generated.

## Structure
- The state enum `pp_ctrl_state_t` {RUN, SWITCH, SETTLE} goes in GLOBAL_PARAM alongside `bw`.
- The SETTLE counter width is `bw(SETTLE_CYC)`.
- One sub-module: `sat_counter` (parameter CNT_W, with `inc` and `clr` ports), instantiated twice under `PP_CTRL_PERF_EN`.

## Test plan
- Reset release, en=1, no other stimulus → `prod_req`=1 at cycle 1; `cons_req`, `switch` and `swap_cnt` remain 0.
- Pulse `prod_done` at cycle 5, SETTLE_CYC=2 → `switch` high in cycle 7 only; `prod_req` and `cons_req` high from cycle 10; `swap_cnt`=1; `bank`=1.
- Producer finishes before consumer: `prod_done` at 20, `cons_done` at 30 → no `switch` until cycle 32.
- Simultaneous `prod_done` and `cons_done`, 100 swaps → 100 `switch` pulses, each at least 5 cycles apart; `swap_cnt`=100.
- `en` dropped while `cons_req`=1, then `cons_done` arrives → swap still occurs; no req rises after SETTLE.
- Async `rst_n` low mid-SETTLE → all outputs 0 immediately. `PP_CTRL_PERF_EN` run: 10 blocked cycles → `prod_stall_cnt`=10.
